// File: rtl/intt_gs_butterfly_if.sv
// Stream interface for the inverse-NTT Gentleman-Sande butterfly: input sample
// channel plus result channel, each with its own valid/ready pair.
interface intt_gs_butterfly_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] w;
    logic             half_en;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, a, b, w, half_en, in_tag, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_tag, out_err
    );

    modport slave (
        input  in_valid, a, b, w, half_en, in_tag, out_ready,
        output in_ready, out_valid, out_a, out_b, out_tag, out_err
    );
endinterface

// File: rtl/intt_gs_butterfly.sv
// Goldilocks GS inverse-NTT butterfly: out_a=(a+b), out_b=(a-b)*w mod M, with
// optional x2^-1 on both results. Three stages, global stall on output backpressure.
module intt_gs_butterfly #(
    parameter int          WIDTH   = 64,
    parameter logic [63:0] MODULUS = 64'hFFFFFFFF00000001,
    parameter int          TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    intt_gs_butterfly_if.slave bus,
    input  logic               err_clr,
    output logic               err_sticky
);
    localparam int               STAGES = 3;
    localparam logic [WIDTH-1:0] M      = MODULUS;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] w;
        logic             half;
        logic [TAG_W-1:0] tag;
        logic             err;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0]   s;
        logic [2*WIDTH-1:0] p;
        logic               half;
        logic [TAG_W-1:0]   tag;
        logic               err;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            adv;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;

    logic [WIDTH-1:0] ac, bc;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lo;
    logic [31:0]      h0, h1;
    logic [WIDTH+1:0] x;
    logic [WIDTH:0]   y;
    logic [WIDTH-1:0] r;

    assign adv           = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];

    // Any 64-bit value is below 2M, so a single conditional subtract canonicalises.
    function automatic logic [WIDTH-1:0] canon(input logic [WIDTH-1:0] v);
        return (v >= M) ? v - M : v;
    endfunction

    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] t;
        t = v[0] ? ({1'b0, v} + {1'b0, M}) : {1'b0, v};
        return t[WIDTH:1];
    endfunction

    always_comb begin
        ac  = canon(bus.a);
        bc  = canon(bus.b);
        sum = {1'b0, ac} + {1'b0, bc};
        if (sum >= {1'b0, M})
            sum = sum - {1'b0, M};
        s1_d.s    = sum[WIDTH-1:0];
        s1_d.d    = (ac >= bc) ? (ac - bc) : (ac + M - bc);
        s1_d.w    = canon(bus.w);
        s1_d.half = bus.half_en;
        s1_d.tag  = bus.in_tag;
        s1_d.err  = (bus.a >= M) || (bus.b >= M) || (bus.w >= M);
    end

    always_comb begin
        s2_d.s    = s1_q.s;
        s2_d.p    = {{WIDTH{1'b0}}, s1_q.d} * {{WIDTH{1'b0}}, s1_q.w};
        s2_d.half = s1_q.half;
        s2_d.tag  = s1_q.tag;
        s2_d.err  = s1_q.err;
    end

    // p = lo + h0*2^64 + h1*2^96 with 2^64 == 2^32-1 and 2^96 == -1 (mod M).
    // Adding M keeps the first fold non-negative; its top bits are at most 2,
    // so the second fold lands below 2M and one subtract finishes.
    always_comb begin
        lo = s2_q.p[63:0];
        h0 = s2_q.p[95:64];
        h1 = s2_q.p[127:96];
        x  = {2'b0, lo} + ({34'b0, h0} << 32) - {34'b0, h0}
           + {2'b0, M} - {34'b0, h1};
        y  = {1'b0, x[WIDTH-1:0]} + ({63'b0, x[WIDTH+1:WIDTH]} << 32)
           - {63'b0, x[WIDTH+1:WIDTH]};
        r  = (y >= {1'b0, M}) ? (y[WIDTH-1:0] - M) : y[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe    <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            bus.out_a   <= '0;
            bus.out_b   <= '0;
            bus.out_tag <= '0;
            bus.out_err <= 1'b0;
        end else if (adv) begin
            vld_pipe    <= {vld_pipe[STAGES-1:1], bus.in_valid};
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            bus.out_a   <= s2_q.half ? halve(s2_q.s) : s2_q.s;
            bus.out_b   <= s2_q.half ? halve(r) : r;
            bus.out_tag <= s2_q.tag;
            bus.out_err <= s2_q.err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (bus.out_valid && bus.out_ready && bus.out_err)
            err_sticky <= 1'b1;
        else if (err_clr)
            err_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Self-checking bench for intt_gs_butterfly: directed vector table, scoreboard
// monitor, stall/hold checks, err_sticky corner cases and mid-flight reset.
module tb_intt_gs_butterfly;
    localparam logic [63:0] M    = 64'hFFFFFFFF00000001;
    localparam logic [63:0] INV2 = 64'h7FFFFFFF80000001;

    typedef struct {
        logic [63:0] ea;
        logic [63:0] eb;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [63:0] a, b, w;
        logic        half;
        logic [63:0] ea, eb;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic err_sticky;
    int   total = 0;
    int   bad = 0;
    int   spurious = 0;
    logic bp_en = 1'b0;
    exp_t sb[$];

    intt_gs_butterfly_if #(.WIDTH(64), .TAG_W(8)) bus ();

    intt_gs_butterfly #(.WIDTH(64), .MODULUS(64'hFFFFFFFF00000001), .TAG_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_clr   (err_clr),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference built on plain % and multiplication by the inverse of 2.
    function automatic exp_t model(input logic [63:0] a, b, w, input logic half, input logic [7:0] tag);
        logic [127:0] ac, bc, wc, s, d, p;
        exp_t e;
        ac = {64'b0, a} % {64'b0, M};
        bc = {64'b0, b} % {64'b0, M};
        wc = {64'b0, w} % {64'b0, M};
        s  = (ac + bc) % {64'b0, M};
        d  = (ac + {64'b0, M} - bc) % {64'b0, M};
        p  = (d * wc) % {64'b0, M};
        if (half) begin
            s = (s * {64'b0, INV2}) % {64'b0, M};
            p = (p * {64'b0, INV2}) % {64'b0, M};
        end
        e.ea  = s[63:0];
        e.eb  = p[63:0];
        e.tag = tag;
        e.err = (a >= M) || (b >= M) || (w >= M);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [63:0] a, b, w, input logic half, input logic [7:0] tag, input exp_t e);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.w = w; bus.half_en = half; bus.in_tag = tag;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_timeout", 192'(n), 192'(0));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 192'(sb.size()), 192'(0));
    endtask

    task automatic monitor();
        logic         held = 1'b0;
        logic [137:0] hv;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                continue;
            end
            if (held)
                chk("hold", 192'({bus.out_valid, bus.out_a, bus.out_b, bus.out_tag, bus.out_err}), 192'(hv));
            if (bus.out_valid && bus.out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) spurious++;
                else begin
                    e = sb.pop_front();
                    chk("out_a", 192'(bus.out_a), 192'(e.ea));
                    chk("out_b", 192'(bus.out_b), 192'(e.eb));
                    chk("out_tag", 192'(bus.out_tag), 192'(e.tag));
                    chk("out_err", 192'(bus.out_err), 192'(e.err));
                end
            end else if (bus.out_valid) begin
                held = 1'b1;
                hv   = {bus.out_valid, bus.out_a, bus.out_b, bus.out_tag, bus.out_err};
            end else
                held = 1'b0;
        end
    endtask

    // Random out_ready with a forced 5-cycle low window early in the burst.
    task automatic bp_drive();
        int n = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                n++;
                bus.out_ready = (n >= 6 && n < 11) ? 1'b0 : 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        vec_t        vt[7];
        exp_t        e;
        int          lat, seen;
        logic [63:0] ra, rb, rw;
        logic        rh;
        logic [7:0]  rt;

        vt[0] = '{a: 64'd5, b: 64'd3, w: 64'd2, half: 1'b0, ea: 64'd8, eb: 64'd4, err: 1'b0};
        vt[1] = '{a: 64'd3, b: 64'd5, w: 64'd1, half: 1'b0, ea: 64'd8, eb: 64'hFFFFFFFEFFFFFFFF, err: 1'b0};
        vt[2] = '{a: M - 64'd1, b: 64'd2, w: 64'd1, half: 1'b0, ea: 64'd1, eb: 64'hFFFFFFFEFFFFFFFE, err: 1'b0};
        vt[3] = '{a: 64'd0, b: 64'd1, w: M - 64'd1, half: 1'b0, ea: 64'd1, eb: 64'd1, err: 1'b0};
        vt[4] = '{a: 64'd5, b: 64'd2, w: 64'd1, half: 1'b1, ea: 64'h7FFFFFFF80000004, eb: 64'h7FFFFFFF80000002, err: 1'b0};
        vt[5] = '{a: 64'd4, b: 64'd2, w: 64'd1, half: 1'b1, ea: 64'd3, eb: 64'd1, err: 1'b0};
        vt[6] = '{a: M, b: 64'd0, w: 64'd1, half: 1'b0, ea: 64'd0, eb: 64'd0, err: 1'b1};

        rst_n = 1'b0; err_clr = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.w = '0;
        bus.half_en = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;
        fork
            monitor();
            bp_drive();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 192'(bus.out_valid), 192'(0));
        chk("rst_out_a", 192'(bus.out_a), 192'(0));
        chk("rst_out_b", 192'(bus.out_b), 192'(0));
        chk("rst_out_tag", 192'(bus.out_tag), 192'(0));
        chk("rst_out_err", 192'(bus.out_err), 192'(0));
        chk("rst_err_sticky", 192'(err_sticky), 192'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // Latency: out_valid on the third negedge after the transfer edge.
        e = '{ea: 64'd8, eb: 64'd4, tag: 8'hA5, err: 1'b0};
        send(64'd5, 64'd3, 64'd2, 1'b0, 8'hA5, e);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 192'(lat), 192'(3));
        @(posedge clk); #1;
        wait_drain();

        for (int i = 0; i < 7; i++) begin
            e = '{ea: vt[i].ea, eb: vt[i].eb, tag: 8'(i + 16), err: vt[i].err};
            send(vt[i].a, vt[i].b, vt[i].w, vt[i].half, 8'(i + 16), e);
        end
        wait_drain();
        chk("sticky_set", 192'(err_sticky), 192'(1));
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr", 192'(err_sticky), 192'(0));
        @(posedge clk); #1;

        // Set beats clear when both land on the same edge.
        bus.out_ready = 1'b0;
        e = '{ea: 64'd0, eb: 64'd0, tag: 8'h5E, err: 1'b1};
        send(M, 64'd0, 64'd1, 1'b0, 8'h5E, e);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("stall_valid", 192'(bus.out_valid), 192'(1));
        @(posedge clk); #1;
        bus.out_ready = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("set_wins", 192'(err_sticky), 192'(1));
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        wait_drain();
        chk("sticky_clr2", 192'(err_sticky), 192'(0));

        // Back-to-back random stream under random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rw = {$urandom, $urandom};
            if (i == 3) ra = 64'hFFFFFFFFFFFFFFFF;
            if (i == 9) rw = M + 64'd7;
            rh = 1'($urandom_range(0, 1));
            rt = 8'(i + 64);
            send(ra, rb, rw, rh, rt, model(ra, rb, rw, rh, rt));
        end
        bp_en = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        // Mid-flight reset with three samples in the pipe.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rw = {$urandom, $urandom};
            send(ra, rb, rw, 1'b0, 8'(i + 128), model(ra, rb, rw, 1'b0, 8'(i + 128)));
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_valid", 192'(bus.out_valid), 192'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 192'(bus.out_valid), 192'(0));
        chk("midrst_out_a", 192'(bus.out_a), 192'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("no_stale", 192'(seen), 192'(0));

        chk("spurious", 192'(spurious), 192'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
